// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front-end sequencer: FSM state encodings,
// default image geometry and the post-frame drain length.
package sobel_pkg;

    localparam int DEF_IMG_W = 5;
    localparam int DEF_IMG_H = 5;
    localparam int DEF_PIX_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Cycles spent after the last accept so the window pipeline can empty.
    localparam int DRAIN_CYCLES = 2;

    // A pixel heads a window when its row is deep enough and either its
    // column is deep enough or border columns are being emitted too.
    function automatic logic in_window(input logic row_ok, input logic col_ok,
                                       input logic border_en);
        return row_ok & (col_ok | border_en);
    endfunction

endpackage

// File: rtl/sobel_pix_counter.sv
// Raster row/column position counter with clear, enable, wrap at the frame
// corner and a flag marking the last pixel of the frame.
module sobel_pix_counter
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       en_i,
    output logic [$clog2(IMG_H)-1:0]   row_o,
    output logic [$clog2(IMG_W)-1:0]   col_o,
    output logic                       last_o
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // Next position: clear wins over advance; column wraps into the next row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                row_d = row_q;
                col_d = col_q + CW'(1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Frame sequencer feeding the double line buffer and flagging 3x3 window
// columns. Optional border-column output enabled by SOBEL_CTRL_BORDER_EN.
module sobel_stream_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       pix_valid_i,
    input  logic [PIX_W-1:0]           pix_i,
    output logic                       pix_ready_o,
    output logic                       lb_we_o,
    output logic [PIX_W-1:0]           lb_data_o,
    output logic                       win_valid_o,
    output logic [$clog2(IMG_H)-1:0]   row_o,
    output logic [$clog2(IMG_W)-1:0]   col_o,
    output logic                       busy_o,
    output logic                       frame_done_o
`ifdef SOBEL_CTRL_BORDER_EN
    ,
    output logic                       border_o
`endif
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
`ifdef SOBEL_CTRL_BORDER_EN
    localparam logic BORDER_EN = 1'b1;
`else
    localparam logic BORDER_EN = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             done_q, done_d;

    logic             accept_s, cnt_clr_s, last_s, row_ok_s, col_ok_s;
    logic [RW-1:0]    cnt_row_s;
    logic [CW-1:0]    cnt_col_s;

    // Stage 1 (write slot) and stage 2 (line-buffer output slot).
    logic             we_q, we_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             win1_q, win1_d;
    logic [RW-1:0]    row1_q, row1_d;
    logic [CW-1:0]    col1_q, col1_d;
    logic             win2_q, win2_d;
    logic [RW-1:0]    row2_q, row2_d;
    logic [CW-1:0]    col2_q, col2_d;
`ifdef SOBEL_CTRL_BORDER_EN
    logic             bord1_q, bord1_d;
    logic             bord2_q, bord2_d;
`endif

    assign accept_s  = pix_valid_i & (state_q == ST_RUN);
    assign cnt_clr_s = start_i & (state_q == ST_IDLE);
    assign row_ok_s  = (cnt_row_s >= RW'(2));
    assign col_ok_s  = (cnt_col_s >= CW'(2));

    sobel_pix_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr_s),
        .en_i   (accept_s),
        .row_o  (cnt_row_s),
        .col_o  (cnt_col_s),
        .last_o (last_s)
    );

    // Frame FSM; frame_done is set for the final drain cycle.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                drain_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                drain_d = '0;
                if (accept_s && last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                    drain_d = '0;
                end else begin
                    state_d = ST_DRAIN;
                    drain_d = drain_q + DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                drain_d = '0;
            end
        endcase
        done_d = (state_d == ST_DRAIN) && (drain_d == DRAIN_LAST);
    end

    // Two-stage pipeline: write slot, then window slot aligned to line-buffer output.
    always_comb begin
        we_d   = accept_s;
        win1_d = accept_s & in_window(row_ok_s, col_ok_s, BORDER_EN);
        row1_d = cnt_row_s;
        col1_d = cnt_col_s;
        win2_d = win1_q;
        if (accept_s) begin
            data_d = pix_i;
        end else begin
            data_d = data_q;
        end
        if (win1_q) begin
            row2_d = row1_q;
            col2_d = col1_q;
        end else begin
            row2_d = row2_q;
            col2_d = col2_q;
        end
`ifdef SOBEL_CTRL_BORDER_EN
        bord1_d = accept_s & row_ok_s & ~col_ok_s;
        bord2_d = win1_q & bord1_q;
`endif
    end

    // All state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            win1_q  <= 1'b0;
            row1_q  <= '0;
            col1_q  <= '0;
            win2_q  <= 1'b0;
            row2_q  <= '0;
            col2_q  <= '0;
`ifdef SOBEL_CTRL_BORDER_EN
            bord1_q <= 1'b0;
            bord2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            we_q    <= we_d;
            data_q  <= data_d;
            win1_q  <= win1_d;
            row1_q  <= row1_d;
            col1_q  <= col1_d;
            win2_q  <= win2_d;
            row2_q  <= row2_d;
            col2_q  <= col2_d;
`ifdef SOBEL_CTRL_BORDER_EN
            bord1_q <= bord1_d;
            bord2_q <= bord2_d;
`endif
        end
    end

    assign pix_ready_o  = (state_q == ST_RUN);
    assign busy_o       = (state_q != ST_IDLE);
    assign lb_we_o      = we_q;
    assign lb_data_o    = data_q;
    assign win_valid_o  = win2_q;
    assign row_o        = row2_q;
    assign col_o        = col2_q;
    assign frame_done_o = done_q;
`ifdef SOBEL_CTRL_BORDER_EN
    assign border_o     = bord2_q;
`endif

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Directed self-checking bench for sobel_stream_ctrl at 5x5: full, gapped,
// misuse and mid-frame reset frames (border build checked when enabled).
module tb_sobel_stream_ctrl;

    localparam int W = 5;
    localparam int H = 5;
`ifdef SOBEL_CTRL_BORDER_EN
    localparam int EXP_WIN  = 15;
    localparam int WIN_COLS = 5;
    localparam int WIN_COL0 = 0;
`else
    localparam int EXP_WIN  = 9;
    localparam int WIN_COLS = 3;
    localparam int WIN_COL0 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       pix_valid_i;
    logic [7:0] pix_i;
    logic       pix_ready_o;
    logic       lb_we_o;
    logic [7:0] lb_data_o;
    logic       win_valid_o;
    logic [2:0] row_o;
    logic [2:0] col_o;
    logic       busy_o;
    logic       frame_done_o;
`ifdef SOBEL_CTRL_BORDER_EN
    logic       border_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int win_cnt  = 0;
    int done_cnt = 0;
    int acc_cyc [W*H];
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_i        (pix_i),
        .pix_ready_o  (pix_ready_o),
        .lb_we_o      (lb_we_o),
        .lb_data_o    (lb_data_o),
        .win_valid_o  (win_valid_o),
        .row_o        (row_o),
        .col_o        (col_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
`ifdef SOBEL_CTRL_BORDER_EN
        ,
        .border_o     (border_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        int er, ec;
        if (prev_done) chk("busy_after_done", busy_o, 0);
        if (lb_we_o) begin
            if (wr_cnt < W*H) begin
                chk("lb_data", lb_data_o, wr_cnt);
                chk("we_timing", cyc, acc_cyc[wr_cnt]);
            end else begin
                chk("wr_overflow", wr_cnt, W*H - 1);
            end
            wr_cnt++;
        end
        if (win_valid_o) begin
            if (win_cnt < EXP_WIN) begin
                er = 2 + win_cnt / WIN_COLS;
                ec = WIN_COL0 + win_cnt % WIN_COLS;
                chk("win_row", row_o, er);
                chk("win_col", col_o, ec);
                chk("win_timing", cyc, acc_cyc[er*W + ec] + 1);
`ifdef SOBEL_CTRL_BORDER_EN
                chk("border_flag", border_o, (ec < 2) ? 1 : 0);
`endif
            end else begin
                chk("win_overflow", win_cnt, EXP_WIN - 1);
            end
            win_cnt++;
        end
`ifdef SOBEL_CTRL_BORDER_EN
        else begin
            chk("border_idle", border_o, 0);
        end
`endif
        if (frame_done_o) begin
            chk("done_with_win", win_valid_o, 1);
            chk("done_win_count", win_cnt, EXP_WIN);
            chk("busy_at_done", busy_o, 1);
            done_cnt++;
        end
        prev_done = frame_done_o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic send(input int v);
        pix_valid_i = 1'b1;
        pix_i       = 8'(v);
        chk("ready_run", pix_ready_o, 1);
        acc_cyc[v]  = cyc + 1;
        tick();
        pix_valid_i = 1'b0;
        pix_i       = 8'd0;
    endtask

    task automatic start_frame();
        wr_cnt   = 0;
        win_cnt  = 0;
        done_cnt = 0;
        chk("ready_idle", pix_ready_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_run", busy_o, 1);
    endtask

    task automatic end_frame(input string name);
        repeat (4) tick();
        chk({name, "_writes"}, wr_cnt, W*H);
        chk({name, "_windows"}, win_cnt, EXP_WIN);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_busy_end"}, busy_o, 0);
        chk({name, "_ready_end"}, pix_ready_o, 0);
        chk({name, "_row_hold"}, row_o, 4);
        chk({name, "_col_hold"}, col_o, 4);
    endtask

    initial begin
        rst         = 1'b0;
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        pix_i       = 8'd0;

        // Reset state
        #12;
        chk("rst_ready", pix_ready_o, 0);
        chk("rst_we", lb_we_o, 0);
        chk("rst_data", lb_data_o, 0);
        chk("rst_win", win_valid_o, 0);
        chk("rst_row", row_o, 0);
        chk("rst_col", col_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", frame_done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        chk("idle_ready", pix_ready_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_we", lb_we_o, 0);

        // Full back-to-back frame
        start_frame();
        for (int v = 0; v < W*H; v++) send(v);
        end_frame("full");

        // Gapped stream
        start_frame();
        for (int v = 0; v < W*H; v++) begin
            send(v);
            tick();
        end
        end_frame("gapped");

        // Valid while idle is ignored
        wr_cnt = 0;
        pix_valid_i = 1'b1;
        pix_i = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            chk("misuse_ready", pix_ready_o, 0);
            tick();
            chk("misuse_we", lb_we_o, 0);
            chk("misuse_busy", busy_o, 0);
        end
        pix_valid_i = 1'b0;
        pix_i = 8'd0;
        chk("misuse_writes", wr_cnt, 0);

        // Start pulse mid-run is ignored
        start_frame();
        for (int v = 0; v < W*H; v++) begin
            start_i = (v == 7) ? 1'b1 : 1'b0;
            send(v);
        end
        start_i = 1'b0;
        end_frame("midstart");

        // Reset mid-frame then restart
        start_frame();
        for (int v = 0; v < 7; v++) send(v);
        chk("pre_rst_we", lb_we_o, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_ready", pix_ready_o, 0);
        chk("mrst_we", lb_we_o, 0);
        chk("mrst_data", lb_data_o, 0);
        chk("mrst_win", win_valid_o, 0);
        chk("mrst_row", row_o, 0);
        chk("mrst_col", col_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", frame_done_o, 0);
        @(negedge clk);
        rst = 1'b1;
        prev_done = 1'b0;
        tick();
        start_frame();
        for (int v = 0; v < W*H; v++) send(v);
        end_frame("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sobel_stream_ctrl.md
# sobel_stream_ctrl

Frame-level sequencer for the Sobel front end. It accepts a raster pixel stream through a valid/ready handshake, drives the write side of `fifo_double_line_buffer`, tracks row/column position, and flags which line-buffer output columns form a complete 3x3 window. It sits between the pixel source and the line buffer plus Sobel kernel, and signals frame completion to the top-level control.

## Interface
Parameters:
- `IMG_W`, 5, pixels per line (≥3)
- `IMG_H`, 5, lines per frame (≥3)
- `PIX_W`, 8, pixel width

Ports:
- `clk`  in  1  single clock, rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `start_i`  in  1  begin a frame; sampled only in IDLE
- `pix_valid_i`  in  1  source pixel valid
- `pix_i`  in  PIX_W  source pixel
- `pix_ready_o`  out  1  controller accepts pixel
- `lb_we_o`  out  1  line-buffer write enable
- `lb_data_o`  out  PIX_W  line-buffer write data
- `win_valid_o`  out  1  line-buffer outputs form a valid window column this cycle
- `row_o`  out  $clog2(IMG_H)  row of the pixel flagged by `win_valid_o`
- `col_o`  out  $clog2(IMG_W)  column of the pixel flagged by `win_valid_o`
- `busy_o`  out  1  frame in progress
- `frame_done_o`  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `pix_ready_o`=0. `start_i`=1 → RUN, with row/col counters cleared to 0.
- RUN: `pix_ready_o`=1. Accept = `pix_valid_i & pix_ready_o`. On accept: col+1; at col=IMG_W-1, col wraps to 0 and row+1. Accepting pixel (IMG_H-1, IMG_W-1) → DRAIN. No accept → counters hold.
- DRAIN: `pix_ready_o`=0. Lasts exactly 2 cycles, then IDLE.
- `start_i` outside IDLE is ignored. `pix_valid_i` outside RUN is ignored, with no side effects.
- Window rule: a pixel produces `win_valid_o` iff row≥2 and col≥2, giving (IMG_H-2)*(IMG_W-2) pulses per frame.
- `busy_o` = state≠IDLE.
- Reset (asynchronous, at any time, including mid-frame): state IDLE; counters 0; every output 0.

## Timing
- Accept at edge N:
  - `lb_we_o`=1 and `lb_data_o`=pixel during cycle N+1 (registered).
  - `win_valid_o`, `row_o`, `col_o` for that pixel during cycle N+2, aligned to the line buffer's 1-cycle output latency.
- Back-to-back accepts produce back-to-back writes; gaps in `pix_valid_i` propagate as gaps in `lb_we_o` and `win_valid_o`.
- `frame_done_o` asserts in the same cycle as the last pixel's N+2 slot. This is the second DRAIN cycle. The next cycle is IDLE.
- `row_o`/`col_o` hold their last value while `win_valid_o`=0.

## Configuration
- `SOBEL_CTRL_BORDER_EN`
  - Defined: adds output `border_o` (1 bit).
    - Window rule relaxes to row≥2 only, giving (IMG_H-2)*IMG_W pulses.
    - `border_o`=1 with `win_valid_o` when col<2, so the kernel zero-fills that output.
    - Reset value of `border_o` is 0.
  - Undefined: no `border_o` port; interior-only rule applies.

## Structure
- Shared package `sobel_pkg`:
  - state encoding constants (IDLE/RUN/DRAIN)
  - default `IMG_W`/`IMG_H`/`PIX_W`
  - DRAIN length constant (2)
- One sub-module: `sobel_pix_counter`, a parameterised row/col counter with enable, clear, wrap and last-pixel flag.
- The two-stage output pipeline and FSM stay in the top level.

## Test plan
All scenarios use IMG_W=5, IMG_H=5.

- Reset: hold `rst`=0 → all outputs 0; release with `start_i`=0 → remains IDLE, `pix_ready_o`=0.
- Full frame: pulse `start_i`, drive 25 back-to-back pixels 0..24 → 25 consecutive `lb_we_o` cycles, `lb_data_o`=0..24 in order; 9 `win_valid_o` pulses (pixels 12,13,14,17,18,19,22,23,24) with `row_o`/`col_o` matching; first pulse 2 cycles after pixel 12 is accepted; `frame_done_o` one pulse with the last window; `busy_o` drops the next cycle.
- Gapped stream: `pix_valid_i` every other cycle → identical data order and 9 windows, each 2 cycles after its accept; counters hold in gap cycles.
- Protocol misuse: `pix_valid_i`=1 in IDLE → `pix_ready_o`=0 and no `lb_we_o`; `start_i` pulse mid-RUN → counters unaffected, frame completes normally.
- Reset mid-frame: assert `rst` after 7 accepts → outputs 0 immediately; new `start_i` restarts at (0,0) and completes a full 25-pixel frame with 9 windows.
- `SOBEL_CTRL_BORDER_EN` defined, full frame → 15 `win_valid_o` pulses (pixels 10..24); `border_o`=1 on 6 of them (col 0,1 of rows 2..4).
